// File: rtl/core_clk_ctrl_pkg.sv
// core_clk_ctrl_pkg
// Shared types and constants for the core clock sequencer.
//   state_e           : sequencer states (step states only with CORE_CLK_CTRL_STEP_EN)
//   CORE_INPUT_CLOCK  : board clock frequency in Hz
//   CORE_DEFAULT_DIV  : reset period, i_clk cycles per core tick
//   TICK_W            : width of the issued-tick counter
// Configuration macro: CORE_CLK_CTRL_STEP_EN (adds STEP / STEP_REL states).
package core_clk_ctrl_pkg;

  localparam int unsigned CORE_INPUT_CLOCK = 16_000_000;
  // Half the board clock: one core tick every 0.5 s at 16 MHz.
  localparam int unsigned CORE_DEFAULT_DIV = CORE_INPUT_CLOCK / 2;
  localparam int unsigned TICK_W           = 16;

  typedef enum logic [1:0] {
    StHalt    = 2'd0,
    StRun     = 2'd1
`ifdef CORE_CLK_CTRL_STEP_EN
    ,
    StStep    = 2'd2,
    StStepRel = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div
// Programmable period divider for the core clock enable.
//   i_clk, i_reset : board clock, async active-high reset
//   i_en           : advance the counter this cycle
//   i_clr          : hold the counter at zero
//   i_load, i_div  : load a new period (0 is clamped to 1); also clears the counter
//   o_tc           : terminal count this cycle (counter wraps); never set on clear/load
module clk_en_div #(
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned RESET_DIV = 8_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tc
);

  localparam logic [DIV_WIDTH-1:0] RstPeriod =
      (RESET_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(RESET_DIV);

  logic [DIV_WIDTH-1:0] r_period;
  logic [DIV_WIDTH-1:0] r_count;
  logic [DIV_WIDTH-1:0] w_period_d;
  logic [DIV_WIDTH-1:0] w_count_d;
  logic [DIV_WIDTH-1:0] w_div_clamped;
  logic                 w_at_term;

  always_comb begin
    w_div_clamped = (i_div == '0) ? DIV_WIDTH'(1) : i_div;
    // Period is never 0, so period-1 cannot underflow.
    w_at_term     = (r_count == (r_period - DIV_WIDTH'(1)));
    w_period_d    = i_load ? w_div_clamped : r_period;

    w_count_d = r_count;
    if (i_load || i_clr) begin
      w_count_d = '0;
    end else if (i_en) begin
      w_count_d = w_at_term ? '0 : (r_count + DIV_WIDTH'(1));
    end

    // A load coinciding with the terminal count wins: no pulse.
    o_tc = i_en && !i_clr && !i_load && w_at_term;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_period <= RstPeriod;
      r_count  <= '0;
    end else begin
      r_period <= w_period_d;
      r_count  <= w_count_d;
    end
  end

endmodule

// File: rtl/core_clk_ctrl.sv
// core_clk_ctrl
// Run / halt / single-step sequencer producing a one-cycle core clock enable.
//   i_clk, i_reset      : board clock, async active-high reset
//   i_run, i_halt       : level requests; halt has priority
//   i_div_load, i_div   : load a new period in i_clk cycles (0 -> 1)
//   i_step_req          : level request for one tick while halted
//   o_step_ack          : one-cycle acknowledge of a step
//   o_clk_en            : one-cycle core clock enable
//   o_running           : high while in RUN
//   o_tick_count        : number of o_clk_en pulses issued (wraps)
// All outputs are registered.
// Configuration macro: CORE_CLK_CTRL_STEP_EN. When undefined the step states are
// absent, i_step_req is ignored and o_step_ack is tied to 0.
module core_clk_ctrl
  import core_clk_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK = CORE_INPUT_CLOCK,
  parameter int unsigned DEFAULT_DIV = INPUT_CLOCK / 2,
  parameter int unsigned DIV_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_halt,
  input  logic                 i_div_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_step_req,
  output logic                 o_step_ack,
  output logic                 o_clk_en,
  output logic                 o_running,
  output logic [TICK_W-1:0]    o_tick_count
);

  state_e              r_state;
  state_e              w_state_d;

  logic                r_clk_en;
  logic                r_step_ack;
  logic                r_running;
  logic [TICK_W-1:0]   r_tick_count;

  logic                w_cnt_en;
  logic                w_cnt_clr;
  logic                w_tc;
  logic                w_step_fire;
  logic                w_clk_en_d;
  logic                w_step_ack_d;
  logic                w_running_d;
  logic [TICK_W-1:0]   w_tick_count_d;

`ifndef CORE_CLK_CTRL_STEP_EN
  logic                w_unused_step_req;
  assign w_unused_step_req = i_step_req;
`endif

  clk_en_div #(
    .DIV_WIDTH (DIV_WIDTH),
    .RESET_DIV (DEFAULT_DIV)
  ) u_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .i_load  (i_div_load),
    .i_div   (i_div),
    .o_tc    (w_tc)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StHalt;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StHalt: begin
        if (i_run && !i_halt) begin
          w_state_d = StRun;
`ifdef CORE_CLK_CTRL_STEP_EN
        end else if (i_step_req) begin
          w_state_d = StStep;
`endif
        end
      end
      StRun: begin
        if (i_halt) begin
          w_state_d = StHalt;
        end
      end
`ifdef CORE_CLK_CTRL_STEP_EN
      StStep: begin
        w_state_d = StStepRel;
      end
      // Held request yields one tick: wait for release before re-arming.
      StStepRel: begin
        if (!i_step_req) begin
          w_state_d = StHalt;
        end
      end
`endif
      default: begin
        w_state_d = StHalt;
      end
    endcase
  end

  // Output / datapath control logic. Registered outputs take their next values here,
  // so a pulse decided at edge N is visible during cycle N+1.
  always_comb begin
    // The counter only runs while staying in RUN; anywhere else it is held at zero,
    // which also gives the clear-on-enter and clear-on-halt behaviour.
    w_cnt_en  = (r_state == StRun) && !i_halt;
    w_cnt_clr = !w_cnt_en;

    w_step_fire = 1'b0;
`ifdef CORE_CLK_CTRL_STEP_EN
    w_step_fire = (r_state == StHalt) && (w_state_d == StStep);
`endif

    w_clk_en_d     = w_tc || w_step_fire;
    w_step_ack_d   = w_step_fire;
    w_running_d    = (w_state_d == StRun);
    w_tick_count_d = r_tick_count + TICK_W'(r_clk_en);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clk_en     <= 1'b0;
      r_step_ack   <= 1'b0;
      r_running    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_clk_en     <= w_clk_en_d;
      r_step_ack   <= w_step_ack_d;
      r_running    <= w_running_d;
      r_tick_count <= w_tick_count_d;
    end
  end

  assign o_clk_en     = r_clk_en;
  assign o_step_ack   = r_step_ack;
  assign o_running    = r_running;
  assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_core_clk_ctrl.sv
module tb_core_clk_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_run;
  logic        i_halt;
  logic        i_div_load;
  logic [31:0] i_div;
  logic        i_step_req;
  logic        o_step_ack;
  logic        o_clk_en;
  logic        o_running;
  logic [15:0] o_tick_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  core_clk_ctrl #(
    .DEFAULT_DIV (4),
    .DIV_WIDTH   (32)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
    .i_halt       (i_halt),
    .i_div_load   (i_div_load),
    .i_div        (i_div),
    .i_step_req   (i_step_req),
    .o_step_ack   (o_step_ack),
    .o_clk_en     (o_clk_en),
    .o_running    (o_running),
    .o_tick_count (o_tick_count)
  );

  // Advance one edge; sample 1 time unit after it.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_run      = 1'b0;
    i_halt     = 1'b0;
    i_div_load = 1'b0;
    i_div      = '0;
    i_step_req = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b0;
  endtask

  task automatic load_div(input logic [31:0] d);
    i_div      = d;
    i_div_load = 1'b1;
    cyc();
    i_div_load = 1'b0;
  endtask

  task automatic stop_run();
    i_run  = 1'b0;
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (o_clk_en !== 1'b0) begin
      n_err++; $display("FAIL reset_clk_en got %b want 0", o_clk_en);
    end
    n_vec++;
    if (o_step_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_step_ack got %b want 0", o_step_ack);
    end
    n_vec++;
    if (o_running !== 1'b0) begin
      n_err++; $display("FAIL reset_running got %b want 0", o_running);
    end
    n_vec++;
    if (o_tick_count !== 16'd0) begin
      n_err++; $display("FAIL reset_tick got %0d want 0", o_tick_count);
    end
  endtask

  // DEFAULT_DIV = 4: pulses 4, 8, 12 cycles after the run sample.
  task automatic test_run_default();
    do_reset();
    i_run = 1'b1;
    cyc();
    n_vec++;
    if (o_running !== 1'b1) begin
      n_err++; $display("FAIL run_running got %b want 1", o_running);
    end
    for (int k = 1; k <= 13; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL run_pulse k=%0d got %b want %b", k, o_clk_en, (k % 4) == 0);
      end
    end
    n_vec++;
    if (o_tick_count !== 16'd3) begin
      n_err++; $display("FAIL run_tick got %0d want 3", o_tick_count);
    end
    stop_run();
    n_vec++;
    if (o_running !== 1'b0) begin
      n_err++; $display("FAIL run_stop_running got %b want 0", o_running);
    end
  endtask

  // D=5; halt (with run still high) sampled at the edge that would give pulse 2.
  task automatic test_halt();
    do_reset();
    load_div(32'd5);
    i_run = 1'b1;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== (k == 5)) begin
        n_err++; $display("FAIL halt_pre k=%0d got %b want %b", k, o_clk_en, k == 5);
      end
    end
    i_halt = 1'b1;
    cyc();
    n_vec++;
    if (o_clk_en !== 1'b0 || o_running !== 1'b0) begin
      n_err++; $display("FAIL halt_now clk_en=%b running=%b want 0/0", o_clk_en, o_running);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== 1'b0) begin
        n_err++; $display("FAIL halt_quiet k=%0d got %b want 0", k, o_clk_en);
      end
    end
    n_vec++;
    if (o_tick_count !== 16'd1) begin
      n_err++; $display("FAIL halt_tick got %0d want 1", o_tick_count);
    end
    i_run  = 1'b0;
    i_halt = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
`ifdef CORE_CLK_CTRL_STEP_EN
    i_step_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== (k == 1) || o_step_ack !== (k == 1)) begin
        n_err++;
        $display("FAIL step_held k=%0d clk_en=%b ack=%b want %b", k, o_clk_en, o_step_ack, k == 1);
      end
    end
    i_step_req = 1'b0;
    cyc();
    i_step_req = 1'b1;
    cyc();
    n_vec++;
    if (o_clk_en !== 1'b1 || o_step_ack !== 1'b1) begin
      n_err++; $display("FAIL step_second clk_en=%b ack=%b want 1/1", o_clk_en, o_step_ack);
    end
    i_step_req = 1'b0;
    cyc();
    n_vec++;
    if (o_clk_en !== 1'b0 || o_step_ack !== 1'b0) begin
      n_err++; $display("FAIL step_end clk_en=%b ack=%b want 0/0", o_clk_en, o_step_ack);
    end
    cyc();
    n_vec++;
    if (o_tick_count !== 16'd2) begin
      n_err++; $display("FAIL step_tick got %0d want 2", o_tick_count);
    end
`else
    i_step_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== 1'b0 || o_step_ack !== 1'b0) begin
        n_err++; $display("FAIL step_off k=%0d clk_en=%b ack=%b want 0/0", k, o_clk_en, o_step_ack);
      end
    end
    i_step_req = 1'b0;
    n_vec++;
    if (o_tick_count !== 16'd0) begin
      n_err++; $display("FAIL step_off_tick got %0d want 0", o_tick_count);
    end
`endif
  endtask

  task automatic test_div_load();
    do_reset();
    load_div(32'd8);
    i_run = 1'b1;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== 1'b0) begin
        n_err++; $display("FAIL div8 k=%0d got %b want 0", k, o_clk_en);
      end
    end
    // Zero clamps to 1: constant enable from the cycle after the load.
    load_div(32'd0);
    n_vec++;
    if (o_clk_en !== 1'b0) begin
      n_err++; $display("FAIL div0_load got %b want 0", o_clk_en);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== 1'b1) begin
        n_err++; $display("FAIL div1_const k=%0d got %b want 1", k, o_clk_en);
      end
    end
    // Load on a terminal-count cycle (period 1): load wins, no pulse.
    load_div(32'd3);
    n_vec++;
    if (o_clk_en !== 1'b0) begin
      n_err++; $display("FAIL div3_load got %b want 0", o_clk_en);
    end
    for (int k = 1; k <= 11; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== ((k % 3) == 0)) begin
        n_err++; $display("FAIL div3 k=%0d got %b want %b", k, o_clk_en, (k % 3) == 0);
      end
    end
    // Next edge would be terminal; reload 3 there.
    load_div(32'd3);
    n_vec++;
    if (o_clk_en !== 1'b0) begin
      n_err++; $display("FAIL div_tc_load got %b want 0", o_clk_en);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== (k == 3)) begin
        n_err++; $display("FAIL div_reload k=%0d got %b want %b", k, o_clk_en, k == 3);
      end
    end
    stop_run();
  endtask

  task automatic test_reset_async();
    do_reset();
    load_div(32'd7);
    i_run = 1'b1;
    cyc();
    for (int k = 1; k <= 7; k++) begin
      cyc();
    end
    n_vec++;
    if (o_clk_en !== 1'b1) begin
      n_err++; $display("FAIL async_pre got %b want 1", o_clk_en);
    end
    #2;
    i_reset = 1'b1;
    i_run   = 1'b0;
    #1;
    n_vec++;
    if (o_clk_en !== 1'b0 || o_running !== 1'b0 || o_step_ack !== 1'b0 || o_tick_count !== 16'd0)
    begin
      n_err++;
      $display("FAIL async_now clk_en=%b running=%b ack=%b tick=%0d want 0/0/0/0",
               o_clk_en, o_running, o_step_ack, o_tick_count);
    end
    cyc();
    cyc();
    n_vec++;
    if (o_clk_en !== 1'b0 || o_running !== 1'b0) begin
      n_err++; $display("FAIL async_held clk_en=%b running=%b want 0/0", o_clk_en, o_running);
    end
    i_reset = 1'b0;
    // Period must be back at DEFAULT_DIV (4), not 7.
    i_run = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_vec++;
      if (o_clk_en !== (k == 4)) begin
        n_err++; $display("FAIL async_default k=%0d got %b want %b", k, o_clk_en, k == 4);
      end
    end
    stop_run();
  endtask

  task automatic test_tick_wrap();
    bit hit;
    do_reset();
    load_div(32'd1);
    i_run = 1'b1;
    cyc();
    hit = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      cyc();
      if (o_tick_count == 16'hFFFF) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!hit) begin
      n_err++; $display("FAIL wrap_reach got %h want ffff within 70000 cycles", o_tick_count);
    end
    n_vec++;
    if (o_clk_en !== 1'b1) begin
      n_err++; $display("FAIL wrap_clk_en got %b want 1", o_clk_en);
    end
    cyc();
    n_vec++;
    if (o_tick_count !== 16'h0000) begin
      n_err++; $display("FAIL wrap_zero got %h want 0000", o_tick_count);
    end
    stop_run();
  endtask

  initial begin
    i_reset    = 1'b1;
    i_run      = 1'b0;
    i_halt     = 1'b0;
    i_div_load = 1'b0;
    i_div      = '0;
    i_step_req = 1'b0;
    #3;
    test_reset();
    test_run_default();
    test_halt();
    test_step();
    test_div_load();
    test_reset_async();
    test_tick_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_clk_ctrl.md
# core_clk_ctrl

Sequencer for the CPU core's clock. It replaces the free-running divider in the board top level with a single-cycle clock-enable (`o_clk_en`) that the core qualifies on the 16 MHz board clock. It provides run, halt and single-step control, a runtime-programmable step period, and a count of issued core ticks for debug. It sits between the top level and `core`, and is driven by the top-level pins or a debug host.

## Interface
- `INPUT_CLOCK`, 16_000_000: board clock frequency in Hz; documentation and default derivation only.
- `DEFAULT_DIV`, 8_000_000: reset value of the period register, in `i_clk` cycles per core tick.
- `DIV_WIDTH`, 32: width of the period register and counter.

Ports:
- `i_clk`, in, 1: board clock. The only clock in the block.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_run`, in, 1: level; request the RUN state.
- `i_halt`, in, 1: level; request the HALT state. Has priority over `i_run`.
- `i_div_load`, in, 1: one-cycle strobe; load `i_div` into the period register.
- `i_div`, in, DIV_WIDTH: new period in cycles.
- `i_step_req`, in, 1: level request for one core tick while halted.
- `o_step_ack`, out, 1: one-cycle acknowledge of a step request.
- `o_clk_en`, out, 1: one-cycle core clock enable.
- `o_running`, out, 1: high while in RUN.
- `o_tick_count`, out, 16: number of `o_clk_en` pulses issued.

## Operation
- All outputs are registered.
- Reset values:
  - state = HALT
  - period register = DEFAULT_DIV
  - counter = 0
  - `o_clk_en`, `o_step_ack` and `o_running` = 0
  - `o_tick_count` = 0
- States: HALT, RUN, STEP, STEP_REL.
- HALT:
  - `i_run`=1 and `i_halt`=0 → RUN; the counter is cleared.
  - Otherwise, `i_step_req`=1 → STEP.
  - `i_run` takes precedence over `i_step_req`.
- RUN:
  - `i_halt`=1 → HALT immediately. The counter is cleared and any pending pulse is dropped.
  - Otherwise the counter increments each cycle. When counter == period-1, the counter wraps to 0 and `o_clk_en` is 1 on the next cycle.
  - `i_step_req` is ignored in RUN; `o_step_ack` stays 0.
- STEP: `o_clk_en`=1 and `o_step_ack`=1 for exactly one cycle, then → STEP_REL.
- STEP_REL: wait until `i_step_req`=0, then → HALT. A held request therefore produces exactly one tick. `i_halt` and `i_run` are ignored in this state.
- Period load:
  - `i_div_load` is accepted in any state.
  - A value of 0 is clamped to 1.
  - The counter is cleared in the same cycle as the load, so the new period starts from the load.
  - A value of 1 makes `o_clk_en` a constant 1 while in RUN.
- `o_tick_count` increments on every cycle in which `o_clk_en`=1, from either RUN or STEP. It wraps 0xFFFF → 0x0000.
- Reset asserted mid-operation forces the reset values asynchronously. No `o_clk_en` pulse is emitted after reset asserts.

## Timing
- If `i_run` is sampled high at edge N (from HALT), `o_running`=1 after edge N and the first `o_clk_en` appears in cycle N+D, where D is the period. After that, pulses repeat every D cycles.
- If `i_halt` is sampled at edge N, `o_running`=0 and `o_clk_en`=0 from cycle N+1.
- If `i_step_req` rises and is sampled at edge N (in HALT), `o_clk_en` and `o_step_ack` are high for cycle N+1 only.
- `i_div_load` at edge N with value D': the next pulse occurs in cycle N+D' when in RUN.
- If `i_div_load` and the terminal count coincide, the load wins: the counter is cleared and no pulse is issued.

## Configuration
- `CORE_CLK_CTRL_STEP_EN` defined: the STEP and STEP_REL states and the step handshake exist, as described above.
- `CORE_CLK_CTRL_STEP_EN` undefined:
  - STEP and STEP_REL are not compiled.
  - `i_step_req` is ignored and `o_step_ack` is tied to 0.
  - All other behaviour is unchanged.

## Structure
- Package `core_clk_ctrl_pkg` holds:
  - the state enum (HALT, RUN, STEP, STEP_REL);
  - the DEFAULT_DIV constant;
  - the tick-count width (16).
- Sub-module `clk_en_div` contains the period register, the zero-clamp, the counter and the terminal-count pulse. Its inputs are enable, clear and load. The FSM and the tick counter live in `core_clk_ctrl`.

## Test plan
- Reset, then `i_run`=1 with DEFAULT_DIV overridden to 4 → `o_clk_en` pulses at cycles 4, 8, 12 after the run sample; `o_tick_count`=3 after the third pulse.
- RUN with D=5, `i_halt` asserted together with `i_run` at the cycle of the 2nd pulse → no further pulses; `o_running`=0 on the next cycle; `o_tick_count` stays at 1.
- HALT, `i_step_req` held high for 10 cycles → exactly one `o_clk_en`/`o_step_ack` pulse. Release and re-assert → a second single pulse; `o_tick_count`=2.
- RUN with D=8, load `i_div`=0 → the period clamps to 1 and `o_clk_en` stays high continuously. Load 3 → pulses every 3 cycles, counted from the load.
- Preload `o_tick_count` to 0xFFFF via 65535 steps (or force it in the bench), then one more step → `o_tick_count`=0x0000.
- Assert `i_reset` asynchronously mid-period in RUN → all outputs are 0 immediately, the state is HALT, and the period is DEFAULT_DIV.
